// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern master: index, counter, LFSR and constant packets
// with programmable length and inter-packet idle gap.
module axis_pattern_gen #(
   parameter int          DATA_WIDTH = 32,
   parameter int          LEN_WIDTH  = 16,
   parameter int          GAP_WIDTH  = 8,
   parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
   parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [GAP_WIDTH-1:0]  gap,
   input  logic [DATA_WIDTH-1:0] const_val,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [31:0]           pkt_count,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] SEED_T = DATA_WIDTH'(LFSR_SEED);
   localparam logic [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] SEED_V = (SEED_T == '0) ? ONE_D : SEED_T;
   localparam logic [DATA_WIDTH-1:0] POLY_V = DATA_WIDTH'(LFSR_POLY);
   localparam logic [LEN_WIDTH-1:0]  ONE_L  = LEN_WIDTH'(1);
   localparam logic [GAP_WIDTH-1:0]  ONE_G  = GAP_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                state_q, state_n;
   logic [1:0]            mode_q, mode_n;
   logic [LEN_WIDTH-1:0]  len_q, len_n;
   logic [GAP_WIDTH-1:0]  gap_q, gap_n;
   logic [DATA_WIDTH-1:0] const_q, const_n;
   logic [LEN_WIDTH-1:0]  idx_q, idx_n;
   logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_n;
   logic [DATA_WIDTH-1:0] run_q, run_n;
   logic [DATA_WIDTH-1:0] lfsr_q, lfsr_n;
   logic [DATA_WIDTH-1:0] tdata_n;
   logic                  tlast_n;
   logic                  tvalid_n;
   logic [31:0]           cnt_n;
   logic                  busy_n;

   logic                  hs;
   logic                  start;
   logic [LEN_WIDTH-1:0]  len_in;
   logic [LEN_WIDTH-1:0]  idx_inc;

   function automatic logic [DATA_WIDTH-1:0] lfsr_step(
      input logic [DATA_WIDTH-1:0] s
   );
      lfsr_step = s[0] ? ((s >> 1) ^ POLY_V) : (s >> 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] beat_data(
      input logic [1:0]            m,
      input logic [LEN_WIDTH-1:0]  i,
      input logic [DATA_WIDTH-1:0] r,
      input logic [DATA_WIDTH-1:0] l,
      input logic [DATA_WIDTH-1:0] c
   );
      case (m)
         2'd0:    beat_data = DATA_WIDTH'(i);
         2'd1:    beat_data = r;
         2'd2:    beat_data = l;
         default: beat_data = c;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         mode_q        <= 2'd0;
         len_q         <= ONE_L;
         gap_q         <= '0;
         const_q       <= '0;
         idx_q         <= '0;
         gcnt_q        <= '0;
         run_q         <= '0;
         lfsr_q        <= SEED_V;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
         pkt_count     <= '0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_n;
         mode_q        <= mode_n;
         len_q         <= len_n;
         gap_q         <= gap_n;
         const_q       <= const_n;
         idx_q         <= idx_n;
         gcnt_q        <= gcnt_n;
         run_q         <= run_n;
         lfsr_q        <= lfsr_n;
         m_axis_tdata  <= tdata_n;
         m_axis_tlast  <= tlast_n;
         m_axis_tvalid <= tvalid_n;
         pkt_count     <= cnt_n;
         busy          <= busy_n;
      end
   end

   always_comb begin
      hs      = m_axis_tvalid & m_axis_tready;
      len_in  = (pkt_len == '0) ? ONE_L : pkt_len;
      idx_inc = idx_q + ONE_L;
      // Generator state advances only on a handshake, so it holds under backpressure.
      run_n   = run_q + {{(DATA_WIDTH-1){1'b0}}, hs};
      lfsr_n  = (hs && mode_q == 2'd2) ? lfsr_step(lfsr_q) : lfsr_q;

      start    = 1'b0;
      state_n  = state_q;
      mode_n   = mode_q;
      len_n    = len_q;
      gap_n    = gap_q;
      const_n  = const_q;
      idx_n    = idx_q;
      gcnt_n   = gcnt_q;
      tdata_n  = m_axis_tdata;
      tlast_n  = m_axis_tlast;
      tvalid_n = m_axis_tvalid;
      cnt_n    = pkt_count;

      unique case (state_q)
         S_IDLE: begin
            if (enable) start = 1'b1;
         end
         S_SEND: begin
            if (hs) begin
               if (m_axis_tlast) begin
                  cnt_n = pkt_count + 32'd1;
                  idx_n = '0;
                  if (gap_q != '0) begin
                     state_n  = S_GAP;
                     gcnt_n   = gap_q;
                     tvalid_n = 1'b0;
                     tlast_n  = 1'b0;
                     tdata_n  = '0;
                  end else if (enable) begin
                     start = 1'b1;
                  end else begin
                     state_n  = S_IDLE;
                     tvalid_n = 1'b0;
                     tlast_n  = 1'b0;
                     tdata_n  = '0;
                  end
               end else begin
                  idx_n   = idx_inc;
                  tlast_n = (idx_inc == len_q - ONE_L);
                  tdata_n = beat_data(mode_q, idx_inc, run_n,
                                      lfsr_n, const_q);
               end
            end
         end
         S_GAP: begin
            if (gcnt_q <= ONE_G) begin
               gcnt_n = '0;
               if (enable) start = 1'b1;
               else state_n = S_IDLE;
            end else begin
               gcnt_n = gcnt_q - ONE_G;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Packet start: latch the config and present beat 0 on the next cycle.
      if (start) begin
         state_n  = S_SEND;
         mode_n   = mode;
         len_n    = len_in;
         gap_n    = gap;
         const_n  = const_val;
         idx_n    = '0;
         tvalid_n = 1'b1;
         tlast_n  = (len_in == ONE_L);
         tdata_n  = beat_data(mode, '0, run_n, lfsr_n, const_val);
      end

      busy_n = (state_n != S_IDLE);
   end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
Parametrised AXI4-Stream master test-pattern source for the FIFO and DMA datapaths. It emits packets of runtime-programmable length with a correct valid/ready handshake. Four data modes are supported: per-packet index, free-running counter, LFSR, and constant. Packets are separated by programmable idle gaps, and completed packets are counted.

Parameters:
DATA_WIDTH, 32, width of m_axis_tdata (>=8)
LEN_WIDTH, 16, width of pkt_len
GAP_WIDTH, 8, width of gap
LFSR_SEED, 32'h0000_0001, LFSR reset value (truncated to DATA_WIDTH; 0 replaced by 1)
LFSR_POLY, 32'h8020_0003, Galois feedback mask (truncated to DATA_WIDTH)

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
enable  in  1  run request; sampled at packet boundaries
mode  in  2  0=packet index, 1=running counter, 2=LFSR, 3=constant
pkt_len  in  LEN_WIDTH  beats per packet; 0 treated as 1
gap  in  GAP_WIDTH  idle cycles between packets
const_val  in  DATA_WIDTH  data for mode 3
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
pkt_count  out  32  packets completed, wraps at 2^32
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; tvalid=0, tlast=0, tdata=0, pkt_count=0, busy=0, beat index=0, running counter=0, LFSR=seed. Reset mid-packet aborts the packet immediately; no tlast is issued.
- All outputs are registered. "Handshake" means tvalid & tready at a posedge.
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND when enable=1. tvalid rises on the cycle after enable is sampled (1-cycle latency).
  - On entry to SEND, latch mode, pkt_len (0->1), gap, and const_val. These stay frozen for the whole packet.
- SEND behaviour:
  - tvalid=1.
  - tdata, tlast, and all generator state hold stable while tready=0.
  - On each handshake, beat index increments and the next beat is presented on the following cycle. There are no bubbles when tready is held high.
- tlast=1 exactly when beat index == latched_len-1.
- On the tlast handshake:
  - pkt_count increments and beat index clears.
  - If latched gap>0, go to GAP.
  - Else if enable=1, stay in SEND with config re-latched; the next packet's first beat is presented the next cycle (back-to-back).
  - Else go to IDLE with tvalid=0 the next cycle.
- GAP: tvalid=0 for exactly latched gap cycles. Then go to SEND (re-latch) if enable=1, else IDLE.
- enable deassert mid-packet does not truncate: the packet completes, then the block stops at the boundary.
- Data per mode (beat 0 of each packet is computed at packet start):
  - mode 0: tdata = beat index, zero-extended or truncated to DATA_WIDTH; restarts at 0 each packet.
  - mode 1: tdata = running counter. It increments on every handshake, is never cleared between packets (rstn only), and wraps modulo 2^DATA_WIDTH.
  - mode 2: tdata = LFSR state. On handshake, next = state[0] ? ((state>>1) ^ POLY) : (state>>1). The LFSR persists across packets and mode changes, and advances only in mode 2.
  - mode 3: tdata = latched const_val.
- Counter and LFSR state do not advance while tready=0.
- pkt_count and the running counter wrap silently to 0 on overflow.
- Changes to mode/pkt_len/gap/const_val mid-packet have no effect until the next latch point.

Test Plan:
- Mode 0, pkt_len=4, gap=0, enable=1, tready=1 -> continuous tdata 0,1,2,3,0,1,... with tlast on each 3; pkt_count=3 after 12 beats; tvalid first high 1 cycle after enable.
- Mode 1, pkt_len=3, gap=2, tready toggling 1/0 each cycle -> tdata 0,1,2 | 2 idle cycles | 3,4,5; values held stable while tready=0; exactly 2 tvalid=0 cycles between tlast and next beat.
- Mode 2, seed=1, POLY=0x80200003 -> first three beats 0x00000001, 0x80200003, 0xC0300002; sequence continues (no restart) into the next packet.
- Mode 3, const_val=0xDEADBEEF, pkt_len=0 -> every packet is a single beat 0xDEADBEEF with tlast=1; pkt_count increments per beat.
- Mode 0, pkt_len=8: deassert enable at beat 2 -> beats 3..7 still sent, tlast on 7, then tvalid=0 and busy=0. Change pkt_len mid-packet -> ignored until the next packet.
- Assert rstn=0 at beat 5 of an 8-beat packet -> next cycle tvalid=0, tlast=0, tdata=0, pkt_count=0. After release with enable=1, a packet restarts from beat 0 and the LFSR restarts from the seed.
